// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and helpers for the TDM word demultiplexer
package tdm_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  // Slot counter width; guarded so a degenerate channel count still yields a legal width.
  function automatic int slot_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/tdm_demux_dec.sv
// rtl/tdm_demux_dec.sv - slot index plus write strobe to one-hot channel write enables
module tdm_demux_dec
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SW   = slot_w(N_CH)
) (
  input  logic [SW-1:0]   sel_i,
  input  logic            we_i,
  output logic [N_CH-1:0] en_o
);

  // Compare per channel so out-of-range codes for non-power-of-two N_CH enable nothing.
  always_comb begin
    en_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      en_o[k] = we_i && (sel_i == SW'(k));
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receiver: slot-steered channel capture with frame sync and error flagging
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  output logic [N_CH*W-1:0] out_data,
  output logic              frame_err
);

  localparam int SW = slot_w(N_CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  tdm_state_t         state_q, state_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [N_CH*W-1:0]  work_q, work_d;
  logic [N_CH*W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               wr_strobe;
  logic [SW-1:0]      wr_slot;
  logic               complete;
  logic [N_CH-1:0]    wr_en;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    wr_strobe   = 1'b0;
    wr_slot     = slot_q;
    complete    = 1'b0;
    frame_err_d = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        SYNC: begin
          if (in_sof) begin
            wr_strobe = 1'b1;
            wr_slot   = '0;
            slot_d    = SLOT_ONE;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (in_sof) begin
            // Early SOF restarts the frame; stale channels are overwritten before completion.
            frame_err_d = (slot_q != '0);
            wr_strobe   = 1'b1;
            wr_slot     = '0;
            slot_d      = SLOT_ONE;
          end else if (slot_q == '0) begin
            frame_err_d = 1'b1;
            state_d     = SYNC;
          end else begin
            wr_strobe = 1'b1;
            wr_slot   = slot_q;
            if (slot_q == LAST_SLOT) begin
              slot_d   = '0;
              complete = 1'b1;
            end else begin
              slot_d = slot_q + SLOT_ONE;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  tdm_demux_dec #(
    .N_CH(N_CH),
    .SW  (SW)
  ) u_dec (
    .sel_i(wr_slot),
    .we_i (wr_strobe),
    .en_o (wr_en)
  );

  // The completed frame is taken from the next-state working set so the final word is included.
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < N_CH; k++) begin
      if (wr_en[k]) work_d[k*W +: W] = in_data;
    end
    out_data_d  = complete ? work_d : out_data_q;
    out_valid_d = complete;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      slot_q      <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

endmodule
